// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Fetch-stage program counter. Holds the PC and advances it by INC each time
//   instruction memory accepts a fetch. Pipeline stalls freeze sequential
//   advance. A branch redirect that arrives during a stall is buffered, and the
//   latest one wins. A trap redirect takes effect on the next edge.
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous reset, active high
//   stall            hazard-unit stall; freezes sequential advance
//   fetch_ready      instruction memory accepts the current address
//   redirect_valid   branch/jump resolved taken this cycle
//   redirect_target  branch/jump target address
//   trap             exception/interrupt request, highest priority
//   pc               current fetch address (registered)
//   pc_plus          pc + INC, combinational, for the IF/ID latch
//   fetch_valid      pc is a valid fetch request
//   redirect_pending a redirect is buffered awaiting stall release
//
// INC must be a power of two and at least 1. Loaded targets are aligned to INC.
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter int              INC          = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            fetch_valid,
  output logic            redirect_pending
);

  localparam logic [XLEN-1:0] INC_W = XLEN'(INC);
  // Clears the low log2(INC) bits. When INC=1 this is all ones, so nothing is masked.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(INC_W - XLEN'(1));
  localparam logic [XLEN-1:0] TRAP_ALIGNED = TRAP_VECTOR & ALIGN_MASK;

  typedef enum logic {BOOT, RUN} state_t;

  state_t          state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pend_target_reg;
  logic            pend_reg;
  logic            fetch_valid_reg;

  logic [XLEN-1:0] redirect_aligned;

  assign redirect_aligned = redirect_target & ALIGN_MASK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= BOOT;
      pc_reg          <= RESET_VECTOR;
      pend_target_reg <= '0;
      pend_reg        <= 1'b0;
      fetch_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        BOOT: begin
          // pc stays at the reset vector. Any redirect seen here is held in the
          // pending register and is applied once the unit is in RUN.
          state_reg       <= RUN;
          fetch_valid_reg <= 1'b1;
          if (trap) begin
            pend_target_reg <= TRAP_ALIGNED;
            pend_reg        <= 1'b1;
          end else if (redirect_valid) begin
            pend_target_reg <= redirect_aligned;
            pend_reg        <= 1'b1;
          end
        end
        RUN: begin
          fetch_valid_reg <= 1'b1;
          if (trap) begin
            pc_reg   <= TRAP_ALIGNED;
            pend_reg <= 1'b0;
          end else if (redirect_valid && !stall) begin
            // The in-flight request is abandoned, so fetch_ready is not needed.
            pc_reg   <= redirect_aligned;
            pend_reg <= 1'b0;
          end else if (redirect_valid) begin
            // Stalled: buffer the redirect. A newer one overwrites an older one.
            pend_target_reg <= redirect_aligned;
            pend_reg        <= 1'b1;
          end else if (pend_reg && !stall) begin
            pc_reg   <= pend_target_reg;
            pend_reg <= 1'b0;
          end else if (!stall && fetch_ready) begin
            pc_reg <= pc_reg + INC_W;
          end
        end
        default: state_reg <= BOOT;
      endcase
    end
  end

  assign pc               = pc_reg;
  assign pc_plus          = pc_reg + INC_W;  // wraps modulo 2^XLEN
  assign fetch_valid      = fetch_valid_reg;
  assign redirect_pending = pend_reg;

endmodule
